// File: rtl/decrypt_pkg.sv
// ---------------------------------------------------------------------------
// decrypt_pkg
//   Shared definitions for the iterative block decryptor:
//     ROUNDS      number of rounds per block (counter reload value)
//     KEYS        number of round keys in the schedule (3 per round)
//     INVS_TABLE  4-bit inverse S-box, entry n is INVS(n)
//     fsm_state_t controller states
//     round_key   K_i = ROTL8(seed, i mod 8) ^ i
// ---------------------------------------------------------------------------
package decrypt_pkg;

    localparam int ROUNDS = 32;
    localparam int KEYS   = 96;

    // Index 0 is the leftmost element, so INVS_TABLE[n] == INVS(n).
    localparam logic [0:15][3:0] INVS_TABLE = {
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Rotating a doubled copy left and keeping the upper byte is an 8-bit
    // rotate-left by i[2:0], i.e. by (i mod 8).
    function automatic logic [7:0] round_key(input logic [6:0] i, input logic [7:0] seed);
        logic [15:0] rot;
        rot = {seed, seed} << i[2:0];
        return rot[15:8] ^ {1'b0, i};
    endfunction

endpackage

// File: rtl/inv_sbox8.sv
// ---------------------------------------------------------------------------
// inv_sbox8
//   Byte-wide inverse S-box: two independent nibble lookups in INVS_TABLE.
//   Ports:
//     din   in  8  byte to substitute
//     dout  out 8  {INVS(din[7:4]), INVS(din[3:0])}
// ---------------------------------------------------------------------------
module inv_sbox8
    import decrypt_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
            assign dout[gi*4 +: 4] = INVS_TABLE[din[gi*4 +: 4]];
        end
    endgenerate

endmodule

// File: rtl/decrypt_core.sv
// ---------------------------------------------------------------------------
// decrypt_core
//   Iterative 32-round decryptor for one 32-bit block (bytes B1..B4).
//   One round per clock: key XOR, byte inverse S-box, key XOR, byte shift.
//   Round r uses keys K_3r, K_3r-1, K_3r-2, so the schedule runs from K_96
//   down to K_1.
//   Ports:
//     CLK               in   1  clock, rising edge
//     RST_N             in   1  asynchronous active-low reset
//     EN                in   1  start request, sampled only in IDLE
//     IN_1..IN_4        in   8  ciphertext bytes B1..B4
//     OUT_1..OUT_4      out  8  plaintext bytes (registered)
//     K_96, K_95, K_94  out  8  constant round keys
//     First_XOR         out  8  B1 ^ ka of the current round
//     S_BOX_OUT         out  8  INVS(First_XOR)
//     Final_XOR         out  8  S_BOX_OUT ^ kb
// ---------------------------------------------------------------------------
module decrypt_core
    import decrypt_pkg::*;
#(
    parameter logic [7:0] KEY_SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [7:0] IN_1,
    input  logic [7:0] IN_2,
    input  logic [7:0] IN_3,
    input  logic [7:0] IN_4,
    output logic [7:0] OUT_1,
    output logic [7:0] OUT_2,
    output logic [7:0] OUT_3,
    output logic [7:0] OUT_4,
    output logic [7:0] K_96,
    output logic [7:0] K_95,
    output logic [7:0] K_94,
    output logic [7:0] First_XOR,
    output logic [7:0] S_BOX_OUT,
    output logic [7:0] Final_XOR
);

    fsm_state_t state_reg, state_next;
    logic [5:0] r_reg, r_next;
    logic [7:0] b1_reg, b2_reg, b3_reg, b4_reg;
    logic [7:0] b1_next, b2_next, b3_next, b4_next;
    logic [7:0] out1_reg, out2_reg, out3_reg, out4_reg;
    logic [7:0] out1_next, out2_next, out3_next, out4_next;

    logic [6:0] idx_a, idx_b, idx_c;
    logic [7:0] ka, kb, kc;

    // Constant keys: pure functions of the seed, unaffected by reset.
    assign K_96 = round_key(7'(KEYS),     KEY_SEED);
    assign K_95 = round_key(7'(KEYS - 1), KEY_SEED);
    assign K_94 = round_key(7'(KEYS - 2), KEY_SEED);

    // Key indices 3r, 3r-1, 3r-2; r stays in 1..32 so idx_c never drops below 1.
    assign idx_a = {1'b0, r_reg} + {r_reg, 1'b0};
    assign idx_b = idx_a - 7'd1;
    assign idx_c = idx_a - 7'd2;

    assign ka = round_key(idx_a, KEY_SEED);
    assign kb = round_key(idx_b, KEY_SEED);
    assign kc = round_key(idx_c, KEY_SEED);

    // Round datapath, always driven from the live state so it doubles as debug.
    assign First_XOR = b1_reg ^ ka;

    inv_sbox8 u_inv_sbox8 (
        .din  (First_XOR),
        .dout (S_BOX_OUT)
    );

    assign Final_XOR = S_BOX_OUT ^ kb;

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        b1_next    = b1_reg;
        b2_next    = b2_reg;
        b3_next    = b3_reg;
        b4_next    = b4_reg;
        out1_next  = out1_reg;
        out2_next  = out2_reg;
        out3_next  = out3_reg;
        out4_next  = out4_reg;

        case (state_reg)
            IDLE: begin
                if (EN) begin
                    b1_next    = IN_1;
                    b2_next    = IN_2;
                    b3_next    = IN_3;
                    b4_next    = IN_4;
                    r_next     = 6'(ROUNDS);
                    state_next = RUN;
                end
            end
            RUN: begin
                b1_next = b2_reg ^ kc;
                b2_next = b3_reg;
                b3_next = b4_reg;
                b4_next = Final_XOR;
                if (r_reg == 6'd1) begin
                    // Last round: publish its result directly, no extra cycle.
                    out1_next  = b1_next;
                    out2_next  = b2_next;
                    out3_next  = b3_next;
                    out4_next  = b4_next;
                    r_next     = 6'(ROUNDS);
                    state_next = IDLE;
                end else begin
                    r_next = r_reg - 6'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            r_reg     <= 6'(ROUNDS);
            b1_reg    <= 8'h00;
            b2_reg    <= 8'h00;
            b3_reg    <= 8'h00;
            b4_reg    <= 8'h00;
            out1_reg  <= 8'h00;
            out2_reg  <= 8'h00;
            out3_reg  <= 8'h00;
            out4_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            b1_reg    <= b1_next;
            b2_reg    <= b2_next;
            b3_reg    <= b3_next;
            b4_reg    <= b4_next;
            out1_reg  <= out1_next;
            out2_reg  <= out2_next;
            out3_reg  <= out3_next;
            out4_reg  <= out4_next;
        end
    end

    assign OUT_1 = out1_reg;
    assign OUT_2 = out2_reg;
    assign OUT_3 = out3_reg;
    assign OUT_4 = out4_reg;

endmodule

// File: tb/tb_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_decrypt_core
//   Directed bench for decrypt_core with a golden-model scoreboard: the
//   expected plaintext is queued when a run is started and popped when the
//   output is due 32 edges after the load edge.
// ---------------------------------------------------------------------------
module tb_decrypt_core;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic [7:0] IN_1, IN_2, IN_3, IN_4;
    logic [7:0] OUT_1, OUT_2, OUT_3, OUT_4;
    logic [7:0] K_96, K_95, K_94;
    logic [7:0] First_XOR, S_BOX_OUT, Final_XOR;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] exp_q [$];
    logic [31:0] prev;
    logic [31:0] dropped;

    decrypt_core dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .IN_1      (IN_1),
        .IN_2      (IN_2),
        .IN_3      (IN_3),
        .IN_4      (IN_4),
        .OUT_1     (OUT_1),
        .OUT_2     (OUT_2),
        .OUT_3     (OUT_3),
        .OUT_4     (OUT_4),
        .K_96      (K_96),
        .K_95      (K_95),
        .K_94      (K_94),
        .First_XOR (First_XOR),
        .S_BOX_OUT (S_BOX_OUT),
        .Final_XOR (Final_XOR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- golden model ----------------
    function automatic logic [7:0] tb_key(input int i);
        logic [7:0] k;
        k = 8'hA5;
        for (int s = 0; s < (i % 8); s++) k = {k[6:0], k[7]};
        return k ^ 8'(i);
    endfunction

    function automatic logic [3:0] tb_invs(input logic [3:0] n);
        case (n)
            4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
            4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
            4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
            4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [31:0] blk);
        logic [7:0] b1, b2, b3, b4, x, s;
        {b1, b2, b3, b4} = blk;
        for (int r = 32; r >= 1; r--) begin
            x = b1 ^ tb_key(3 * r);
            s = {tb_invs(x[7:4]), tb_invs(x[3:0])};
            {b1, b2, b3, b4} = {b2 ^ tb_key(3 * r - 2), b3, b4, s ^ tb_key(3 * r - 1)};
        end
        return {b1, b2, b3, b4};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [31:0] out_word();
        return {OUT_1, OUT_2, OUT_3, OUT_4};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [31:0] v);
        {IN_1, IN_2, IN_3, IN_4} = v;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_view(input string tag);
        chk32({tag, "_out"},   out_word(), 32'h0);
        chk8({tag, "_fxor"},   First_XOR,  8'hC5);
        chk8({tag, "_sbox"},   S_BOX_OUT,  8'h01);
        chk8({tag, "_final"},  Final_XOR,  8'h8C);
    endtask

    // Follows a run from edge (done+1) to the completion edge L+32: OUT must
    // hold its previous value until then, and match the scoreboard head at L+32.
    task automatic follow_run(input int done, input logic [31:0] hold);
        logic [31:0] exp;
        for (int k = done + 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                chk32("out_hold_during_run", out_word(), hold);
            end else begin
                n_asserts++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL scoreboard_empty observed=%0d expected=%0d", exp_q.size(), 1);
                end
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    chk32("out_result", out_word(), exp);
                    $display("run done: out=%h expected=%h", out_word(), exp);
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 1'b0;
        EN    = 1'b0;
        set_in(32'h0);
        tick();
        tick();

        // Reset state and constant keys
        chk_reset_view("reset");
        chk8("k96", K_96, 8'hC5);
        chk8("k95", K_95, 8'h8D);
        chk8("k94", K_94, 8'h37);

        // Run 1: F1 03 4A 71, EN held high
        set_in(32'hF1034A71);
        EN    = 1'b1;
        RST_N = 1'b1;
        exp_q.push_back(model(32'hF1034A71));
        tick();                                   // load edge L
        chk8("load_fxor",  First_XOR, 8'h34);
        chk8("load_sbox",  S_BOX_OUT, 8'h8C);
        chk8("load_final", Final_XOR, 8'h01);
        tick();                                   // L+1
        chk8("round1_fxor", First_XOR, 8'hDD);
        set_in(32'h12345678);                     // must not affect run 1
        follow_run(1, 32'h0);                     // through L+32

        // Run 2 loads automatically at L+33 since EN is still high
        prev = out_word();
        exp_q.push_back(model(32'h12345678));
        tick();                                   // L+33
        chk32("out_stable_l33", out_word(), prev);
        EN = 1'b0;                                // run completes regardless
        set_in(32'hDEADBEEF);
        follow_run(0, prev);                      // through L+65

        // Idle: no further loads, OUT frozen while IN keeps changing
        prev = out_word();
        for (int k = 0; k < 40; k++) begin
            set_in($urandom);
            tick();
            chk32("out_idle_hold", out_word(), prev);
        end

        // Run 3 aborted by reset mid-run
        set_in(32'h0BADF00D);
        EN = 1'b1;
        exp_q.push_back(model(32'h0BADF00D));
        tick();                                   // load
        EN = 1'b0;
        repeat (10) tick();
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_view("abort");
        dropped = exp_q.pop_back();
        $display("run aborted by reset: discarded expected=%h", dropped);
        tick();

        // Run 4: same input, must give the full result
        RST_N = 1'b1;
        EN    = 1'b1;
        exp_q.push_back(model(32'h0BADF00D));
        tick();                                   // load
        EN = 1'b0;
        follow_run(0, 32'h0);

        chk32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
